mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multi-cycle sequencer for the MIPS core. It replaces single-cycle main decoding with a Moore-style state machine that steps the shared datapath (one ALU, one unified memory port, IR, PC) through fetch, decode, execute, memory and writeback, one phase per clock. A ready handshake with memory and a bounded wait timer are included. It sits between the instruction register's opcode field and the datapath control inputs.

## Interface
- TIMEOUT, default 15: maximum wait cycles for mem_ready in any memory state (1..255).
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- opcode  input  6  IR[31:26]; sampled in DECODE and MEMADR.
- zero  input  1  ALU zero flag; informational only (datapath ANDs it with PCWriteCond).
- mem_ready  input  1  memory completes the current read or write this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  output  1 each  datapath enables and selects.
- RegDst, MemtoReg, RegWrite, ALUSrcA, Jal  output  1 each  register-file and ALU selects.
- ALUSrcB  output  2  00 reg B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- AluOP  output  2  00 add, 01 sub, 10 funct-decoded.
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  output  4  current state encoding, for debug.
- illegal_op  output  1  one-cycle pulse on an unknown opcode.
- mem_err  output  1  one-cycle pulse on a memory wait timeout.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, JALS 10, ILLEGAL 11. Encodings 12–15 return to FETCH on the next cycle with all outputs at 0.
- Every output not listed for a state is 0.
- FETCH
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOP=00, PCSource=00.
  - IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; that cycle the FSM moves to DECODE.
- DECODE
  - ALUSrcA=0, ALUSrcB=11, AluOP=00 (branch target into ALUOut).
  - Next state by opcode: 000000 → EXEC; 100011 or 101011 → MEMADR; 000100 → BRANCH; 000010 → JUMP; 000011 → JALS; any other → ILLEGAL.
- MEMADR: ALUSrcA=1, ALUSrcB=10, AluOP=00. Next state: lw → MEMRD; sw → MEMWR.
- MEMRD: MemRead=1, IorD=1. Moves to MEMWB on mem_ready.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Moves to FETCH on mem_ready.
- EXEC: ALUSrcA=1, ALUSrcB=00, AluOP=10. Next state ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, AluOP=01, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- JALS: PCWrite=1, PCSource=10, RegWrite=1, Jal=1 (datapath writes PC to $31). Next state FETCH.
- ILLEGAL: illegal_op=1. Next state FETCH; the instruction is skipped.
- Wait timer
  - 8-bit counter, cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle spent in one of those states without mem_ready.
  - When the count reaches TIMEOUT with mem_ready=0: mem_err pulses for that cycle. MEMRD or MEMWR is abandoned and the FSM goes to FETCH, with no register write. In FETCH the counter clears and the fetch retries; PC is not advanced.
  - mem_ready and the timeout in the same cycle: mem_ready wins and mem_err stays 0.

## Timing
- All outputs are decoded from the state register. IRWrite and PCWrite in FETCH are additionally gated by mem_ready.
- Reset value, and value throughout reset: state=FETCH, timer=0. All write enables, MemRead, illegal_op and mem_err are forced to 0 while reset is high.
- Reset asserted mid-instruction aborts immediately. No write enable is seen after the rising edge of reset.
- Latency with zero-wait memory (mem_ready high in the first cycle):
  - R-type: 4 cycles. lw: 5. sw: 4. beq: 3. j/jal: 3. illegal: 3.
  - Each wait cycle adds one cycle.
- mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.

## Configuration
- MC_CTRL_PERF_EN defined: adds cycle_count[31:0] and instr_count[31:0] output ports.
  - Both are reset to 0.
  - cycle_count increments every clock out of reset.
  - instr_count increments on each completed fetch (FETCH with mem_ready=1).
  - Both wrap at 2^32.
- Undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Package mc_ctrl_pkg holds:
  - state encoding constants;
  - opcode constants (R, LW, SW, BEQ, J, JAL);
  - ALUSrcB, AluOP and PCSource encodings.
- Sub-module mem_wait_timer: clear, count-enable, TIMEOUT parameter, expired flag. Instantiated once.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1 and opcode 000000: states 0,1,6,7,0. RegWrite=1 only in the ALUWB cycle; all enables are 0 during reset.
- lw (100011) with mem_ready low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0; MemtoReg=1 and RegWrite=1 in state 4.
- beq (000100), zero=1: PCWriteCond=1, PCSource=01, AluOP=01 in state 8; the total instruction takes 3 cycles.
- jal (000011): state 10 asserts PCWrite=1, RegWrite=1, Jal=1, PCSource=10.
- Opcode 111111: illegal_op pulses once in state 11; the next state is FETCH with no RegWrite or MemWrite.
- sw (101011) with mem_ready held low and TIMEOUT=4: mem_err pulses on the 4th wait cycle, the FSM returns to FETCH, and MemWrite drops the next cycle. Asserting reset mid-MEMWR forces state 0 asynchronously.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
// States, opcodes, datapath select codes and the control bundle.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_JALS    = 4'd10,
      S_ILLEGAL = 4'd11
   } state_e;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_JAL = 6'b000011;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       memto_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic       jal;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   // States that wait on the memory handshake and run the timer.
   function automatic logic is_wait_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded wait counter for memory handshakes.
// expired_o flags the TIMEOUT-th consecutive counted cycle.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Clear has priority; otherwise count each enabled cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Moore sequencer stepping the shared MIPS datapath one phase per clock.
// Optional MC_CTRL_PERF_EN adds cycle_count / instr_count ports.
module mc_ctrl_fsm #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegDst,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        ALUSrcA,
   output logic        Jal,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  AluOP,
   output logic [1:0]  PCSource,
   output logic [3:0]  state,
   output logic        illegal_op,
   output logic        mem_err
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] instr_count
`endif
);

   import mc_ctrl_pkg::*;

   state_e state_q;
   state_e state_d;
   ctrl_t  c;
   logic   tmr_en;
   logic   tmr_clr;
   logic   tmr_exp;

   // The zero flag is consumed by the datapath, not here.
   logic unused_zero;
   assign unused_zero = zero;

   // Timer counts stalled cycles; any exit or non-wait state clears it.
   assign tmr_en  = is_wait_state(state_q) && !mem_ready;
   assign tmr_clr = !tmr_en || tmr_exp;

   mem_wait_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .clk_i    (clk),
      .rst_i    (reset),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .expired_o(tmr_exp)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-state control decode.
   always_comb begin
      state_d = state_q;
      c       = CTRL_IDLE;
      unique case (state_q)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALUOP_ADD;
            c.pc_source = PCSRC_ALU;
            if (mem_ready) begin
               c.ir_write = 1'b1;
               c.pc_write = 1'b1;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_IMMSH;
            c.alu_op    = ALUOP_ADD;
            unique case (opcode)
               OP_R:         state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_JAL:       state_d = S_JALS;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
            if (opcode == OP_LW) begin
               state_d = S_MEMRD;
            end else if (opcode == OP_SW) begin
               state_d = S_MEMWR;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEMRD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
            if (mem_ready) begin
               state_d = S_MEMWB;
            end else if (tmr_exp) begin
               state_d = S_FETCH;
            end
         end
         S_MEMWB: begin
            c.memto_reg = 1'b1;
            c.reg_write = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEMWR: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
            if (mem_ready || tmr_exp) begin
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_REG;
            c.alu_op    = ALUOP_FUNCT;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_REG;
            c.alu_op        = ALUOP_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCSRC_ALUOUT;
            state_d         = S_FETCH;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_JUMP;
            state_d     = S_FETCH;
         end
         S_JALS: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCSRC_JUMP;
            c.reg_write = 1'b1;
            c.jal       = 1'b1;
            state_d     = S_FETCH;
         end
         S_ILLEGAL: begin
            c.illegal_op = 1'b1;
            state_d      = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Enables are held low for the whole reset window.
   assign PCWrite     = c.pc_write      && !reset;
   assign PCWriteCond = c.pc_write_cond && !reset;
   assign MemRead     = c.mem_read      && !reset;
   assign MemWrite    = c.mem_write     && !reset;
   assign IRWrite     = c.ir_write      && !reset;
   assign RegWrite    = c.reg_write     && !reset;
   assign illegal_op  = c.illegal_op    && !reset;
   assign mem_err     = tmr_exp         && !reset;
   assign IorD        = c.iord;
   assign RegDst      = c.reg_dst;
   assign MemtoReg    = c.memto_reg;
   assign ALUSrcA     = c.alu_src_a;
   assign Jal         = c.jal;
   assign ALUSrcB     = c.alu_src_b;
   assign AluOP       = c.alu_op;
   assign PCSource    = c.pc_source;
   assign state       = state_q;

`ifdef MC_CTRL_PERF_EN
   logic [31:0] cyc_q;
   logic [31:0] ins_q;

   // Free-running cycle and completed-fetch counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else begin
         cyc_q <= cyc_q + 32'd1;
         if (state_q == S_FETCH && mem_ready) begin
            ins_q <= ins_q + 32'd1;
         end
      end
   end

   assign cycle_count = cyc_q;
   assign instr_count = ins_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm (TIMEOUT=4).
// Expected traces are built per instruction from latency and wait rules.
module tb_mc_ctrl_fsm;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  opcode = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic        RegDst, MemtoReg, RegWrite, ALUSrcA, Jal;
   logic [1:0]  ALUSrcB, AluOP, PCSource;
   logic [3:0]  state;
   logic        illegal_op, mem_err;
`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycle_count, instr_count;
`endif

   mc_ctrl_fsm #(.TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .Jal(Jal), .ALUSrcB(ALUSrcB), .AluOP(AluOP),
      .PCSource(PCSource), .state(state), .illegal_op(illegal_op),
      .mem_err(mem_err)
`ifdef MC_CTRL_PERF_EN
      , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nbad = 0;

   typedef struct {
      logic [3:0] st;
      logic       mr;
      logic       err;
   } step_t;

   step_t q[$];

   logic [18:0] got;
   assign got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                 RegDst, MemtoReg, RegWrite, ALUSrcA, Jal,
                 ALUSrcB, AluOP, PCSource, illegal_op, mem_err};

   // Control table per phase, straight from the state descriptions.
   function automatic logic [18:0] exp_ctrl(input logic [3:0] st,
                                            input logic mr,
                                            input logic err);
      logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, srca, jl, ill, me;
      logic [1:0] srcb, aop, pcs;
      {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, srca, jl, ill, me} = '0;
      srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
      case (st)
         4'd0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; me = err; end
         4'd1:  begin srcb = 2'b11; end
         4'd2:  begin srca = 1; srcb = 2'b10; end
         4'd3:  begin mrd = 1; iord = 1; me = err; end
         4'd4:  begin m2r = 1; rw = 1; end
         4'd5:  begin mwr = 1; iord = 1; me = err; end
         4'd6:  begin srca = 1; aop = 2'b10; end
         4'd7:  begin rdst = 1; rw = 1; end
         4'd8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         4'd9:  begin pcw = 1; pcs = 2'b10; end
         4'd10: begin pcw = 1; pcs = 2'b10; rw = 1; jl = 1; end
         4'd11: begin ill = 1; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, srca, jl,
              srcb, aop, pcs, ill, me};
   endfunction

   // While reset is high: FETCH selects, every enable low.
   function automatic logic [18:0] rst_ctrl();
      return exp_ctrl(4'd0, 1'b0, 1'b0) & ~19'h08000;
   endfunction

   task automatic check(input string tag, input logic [3:0] est,
                        input logic [18:0] ectl);
      nvec++;
      assert (state === est) else begin
         nbad++;
         $error("FAIL %s state got %0d want %0d", tag, state, est);
      end
      nvec++;
      assert (got === ectl) else begin
         nbad++;
         $error("FAIL %s ctrl st%0d got %b want %b", tag, est, got, ectl);
      end
   endtask

   task automatic push(input logic [3:0] st, input logic mr, input logic err);
      step_t s;
      s.st = st; s.mr = mr; s.err = err;
      q.push_back(s);
   endtask

   // w stalled cycles then ready, or abandon after T stalls.
   task automatic add_wait(input logic [3:0] st, input int w,
                           output bit to);
      if (w >= T) begin
         for (int i = 0; i < T - 1; i++) push(st, 1'b0, 1'b0);
         push(st, 1'b0, 1'b1);
         to = 1'b1;
      end else begin
         for (int i = 0; i < w; i++) push(st, 1'b0, 1'b0);
         push(st, 1'b1, 1'b0);
         to = 1'b0;
      end
   endtask

   task automatic build(input logic [5:0] op, input int wf, input int wm);
      bit to;
      add_wait(4'd0, wf, to);
      while (to) add_wait(4'd0, $urandom_range(0, 2), to);
      push(4'd1, 1'($urandom), 1'b0);
      case (op)
         6'b000000: begin push(4'd6, 1'($urandom), 0); push(4'd7, 1'($urandom), 0); end
         6'b100011: begin
            push(4'd2, 1'($urandom), 1'b0);
            add_wait(4'd3, wm, to);
            if (!to) push(4'd4, 1'($urandom), 1'b0);
         end
         6'b101011: begin
            push(4'd2, 1'($urandom), 1'b0);
            add_wait(4'd5, wm, to);
         end
         6'b000100: push(4'd8, 1'($urandom), 1'b0);
         6'b000010: push(4'd9, 1'($urandom), 1'b0);
         6'b000011: push(4'd10, 1'($urandom), 1'b0);
         default:   push(4'd11, 1'($urandom), 1'b0);
      endcase
   endtask

   // Replay the queued trace; optionally hit reset inside MEMWR.
   task automatic run(input string tag, input logic [5:0] op,
                      input bit abort);
      step_t s;
      while (q.size() > 0) begin
         s = q.pop_front();
         @(negedge clk);
         reset = 1'b0;
         mem_ready = s.mr;
         zero = 1'($urandom);
         opcode = (s.st == 4'd1 || s.st == 4'd2) ? op : 6'($urandom);
         #1 check(tag, s.st, exp_ctrl(s.st, s.mr, s.err));
         if (abort && s.st == 4'd5) begin
            reset = 1'b1;
            #1 check({tag, "_rst"}, 4'd0, rst_ctrl());
            q.delete();
            @(negedge clk);
            #1 check({tag, "_rsthold"}, 4'd0, rst_ctrl());
         end
      end
   endtask

   function automatic logic [5:0] pick_op(input int k);
      logic [5:0] o;
      case (k)
         0: o = 6'b000000;
         1: o = 6'b100011;
         2: o = 6'b101011;
         3: o = 6'b000100;
         4: o = 6'b000010;
         5: o = 6'b000011;
         default: begin
            do o = 6'($urandom);
            while (o inside {6'b000000, 6'b100011, 6'b101011,
                             6'b000100, 6'b000010, 6'b000011});
         end
      endcase
      return o;
   endfunction

   initial begin
      logic [5:0] op;
      reset = 1'b1;
      mem_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1 check("reset", 4'd0, rst_ctrl());
      end

      build(6'b000000, 0, 0);  run("rtype", 6'b000000, 1'b0);
      build(6'b100011, 0, 2);  run("lw",    6'b100011, 1'b0);
      build(6'b000100, 0, 0);  run("beq",   6'b000100, 1'b0);
      build(6'b000011, 0, 0);  run("jal",   6'b000011, 1'b0);
      build(6'b111111, 0, 0);  run("ill",   6'b111111, 1'b0);
      build(6'b101011, 0, 9);  run("swto",  6'b101011, 1'b0);
      build(6'b000000, 6, 0);  run("fetto", 6'b000000, 1'b0);
      build(6'b101011, 1, 3);  run("swrst", 6'b101011, 1'b1);

      repeat (300) begin
         op = pick_op($urandom_range(0, 6));
         build(op, $urandom_range(0, 5), $urandom_range(0, 6));
         run("rand", op, ($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
